// File: rtl/stepper_pkg.sv
// Shared register map, state encoding and coil phase tables for the stepper controller.
// Build option: define STEPPER_HALF_STEP_EN for the 8-entry half-step sequence (default: 4-entry full-step).
package stepper_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_TARGET = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_W     = 5;
  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_HOME  = 2;
  localparam int CTRL_ABORT = 3;
  localparam int CTRL_HOLD  = 4;

  localparam int STAT_W         = 7;
  localparam int STAT_BUSY      = 0;
  localparam int STAT_DONE      = 1;
  localparam int STAT_HOMED     = 2;
  localparam int STAT_FAULT     = 3;
  localparam int STAT_PHASE_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOME = 2'd2
  } ch_state_e;

  // Entry 0 is the rightmost element of each concatenation.
  localparam logic [3:0][3:0] FULL_SEQ = {4'b1001, 4'b0011, 4'b0110, 4'b1100};
  localparam logic [7:0][3:0] HALF_SEQ = {4'b1001, 4'b0001, 4'b0011, 4'b0010,
                                          4'b0110, 4'b0100, 4'b1100, 4'b1000};

`ifdef STEPPER_HALF_STEP_EN
  localparam int PH_W = 3;
  localparam logic [7:0][3:0] SEQ = HALF_SEQ;
`else
  localparam int PH_W = 2;
  localparam logic [3:0][3:0] SEQ = FULL_SEQ;
`endif

  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] phase, input logic fwd);
    return fwd ? phase + PH_W'(1) : phase - PH_W'(1);
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: CTRL/PERIOD/TARGET registers, run/home FSM, step divider,
// limit synchroniser and coil drive.
module stepper_channel
  import stepper_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int STEP_W   = 16,
  parameter int POS_W    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ctrl_we_i,
  input  logic                period_we_i,
  input  logic                target_we_i,
  input  logic [31:0]         wr_data_i,
  input  logic                limit_i,
  output logic [3:0]          coils_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic [STEP_W-1:0]   target_o,
  output logic [STAT_W-1:0]   status_o,
  output logic [POS_W-1:0]    pos_o
);

  ch_state_e           state_q, state_d;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [STEP_W-1:0]   target_q, target_d;
  logic [PERIOD_W-1:0] per_s_q, per_s_d;
  logic [STEP_W-1:0]   tgt_s_q, tgt_s_d;
  logic [PERIOD_W-1:0] div_q, div_d;
  logic [STEP_W-1:0]   steps_q, steps_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic                dir_q, dir_d;
  logic                done_q, done_d;
  logic                homed_q, homed_d;
  logic                fault_q, fault_d;
  logic                lim_meta_q, lim_sync_q;
  logic                step;
  logic [PERIOD_W-1:0] period_eff;

  assign period_eff = (period_q < PERIOD_W'(2)) ? PERIOD_W'(2) : period_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ctrl_q     <= '0;
      period_q   <= '0;
      target_q   <= '0;
      per_s_q    <= '0;
      tgt_s_q    <= '0;
      div_q      <= '0;
      steps_q    <= '0;
      phase_q    <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      done_q     <= 1'b0;
      homed_q    <= 1'b0;
      fault_q    <= 1'b0;
      lim_meta_q <= 1'b0;
      lim_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      target_q   <= target_d;
      per_s_q    <= per_s_d;
      tgt_s_q    <= tgt_s_d;
      div_q      <= div_d;
      steps_q    <= steps_d;
      phase_q    <= phase_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      done_q     <= done_d;
      homed_q    <= homed_d;
      fault_q    <= fault_d;
      lim_meta_q <= limit_i;
      lim_sync_q <= lim_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    period_d = period_q;
    target_d = target_q;
    per_s_d  = per_s_q;
    tgt_s_d  = tgt_s_q;
    div_d    = div_q;
    steps_d  = steps_q;
    phase_d  = phase_q;
    pos_d    = pos_q;
    dir_d    = dir_q;
    done_d   = done_q;
    homed_d  = homed_q;
    fault_d  = fault_q;
    step     = 1'b0;

    if (ctrl_we_i)   ctrl_d   = CTRL_W'(wr_data_i);
    if (period_we_i) period_d = PERIOD_W'(wr_data_i);
    if (target_we_i) target_d = STEP_W'(wr_data_i);

    if (ctrl_we_i && wr_data_i[CTRL_ABORT]) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ctrl_we_i && (wr_data_i[CTRL_HOME] || wr_data_i[CTRL_START])) begin
            state_d = wr_data_i[CTRL_HOME] ? ST_HOME : ST_RUN;
            dir_d   = wr_data_i[CTRL_HOME] ? 1'b0 : wr_data_i[CTRL_DIR];
            done_d  = 1'b0;
            fault_d = 1'b0;
            per_s_d = period_eff;
            tgt_s_d = target_q;
            div_d   = period_eff - PERIOD_W'(1);
            steps_d = '0;
          end
        end
        ST_RUN: begin
          if (lim_sync_q && !dir_q) begin
            state_d = ST_IDLE;
            fault_d = 1'b1;
          end else if (steps_q == tgt_s_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            step = (div_q == '0);
          end
        end
        ST_HOME: begin
          if (lim_sync_q) begin
            state_d = ST_IDLE;
            pos_d   = '0;
            homed_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            step = (div_q == '0);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The divider only runs while moving; a step reloads it for the next period.
    if (state_d == state_q && state_q != ST_IDLE) begin
      if (step) begin
        div_d   = per_s_q - PERIOD_W'(1);
        steps_d = steps_q + STEP_W'(1);
        phase_d = next_phase(phase_q, dir_q);
        pos_d   = dir_q ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end else begin
        div_d = div_q - PERIOD_W'(1);
      end
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign done_o   = done_q;
  assign ctrl_o   = ctrl_q;
  assign period_o = period_q;
  assign target_o = target_q;
  assign pos_o    = pos_q;
  assign status_o = {3'(phase_q), fault_q, homed_q, done_q, busy_o};
  assign coils_o  = (busy_o || ctrl_q[CTRL_HOLD]) ? SEQ[phase_q] : 4'b0000;

endmodule

// File: rtl/stepper_io_ctrl.sv
// Multi-channel memory-mapped stepper controller: address decode, registered read mux,
// done interrupt and one stepper_channel per coil port.
module stepper_io_ctrl
  import stepper_pkg::*;
#(
  parameter int N_CH     = 2,
  parameter int PERIOD_W = 24,
  parameter int STEP_W   = 16,
  parameter int POS_W    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(N_CH)+1:0]  addr,
  input  logic [31:0]              wr_data,
  output logic [31:0]              rd_data,
  output logic [4*N_CH-1:0]        coils,
  input  logic [N_CH-1:0]          limit,
  output logic [N_CH-1:0]          busy,
  output logic                     irq
);

  localparam int AW = $clog2(N_CH) + 2;

  logic [AW-1:0]       ch_sel;
  logic [N_CH-1:0]     done_v;
  logic [CTRL_W-1:0]   ctrl_w   [N_CH];
  logic [PERIOD_W-1:0] period_w [N_CH];
  logic [STEP_W-1:0]   target_w [N_CH];
  logic [STAT_W-1:0]   status_w [N_CH];
  logic [POS_W-1:0]    pos_w    [N_CH];
  logic [31:0]         pos32    [N_CH];
  logic [31:0]         rd_data_q, rd_data_d;

  assign ch_sel = addr >> 2;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic ch_we;
    assign ch_we    = wr_en && (ch_sel == AW'(c));
    assign pos32[c] = 32'($signed(pos_w[c]));

    stepper_channel #(
      .PERIOD_W (PERIOD_W),
      .STEP_W   (STEP_W),
      .POS_W    (POS_W)
    ) u_ch (
      .clk_i       (clock),
      .rst_i       (reset),
      .ctrl_we_i   (ch_we && addr[1:0] == REG_CTRL),
      .period_we_i (ch_we && addr[1:0] == REG_PERIOD),
      .target_we_i (ch_we && addr[1:0] == REG_TARGET),
      .wr_data_i   (wr_data),
      .limit_i     (limit[c]),
      .coils_o     (coils[4*c +: 4]),
      .busy_o      (busy[c]),
      .done_o      (done_v[c]),
      .ctrl_o      (ctrl_w[c]),
      .period_o    (period_w[c]),
      .target_o    (target_w[c]),
      .status_o    (status_w[c]),
      .pos_o       (pos_w[c])
    );
  end

  always_comb begin
    rd_data_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_sel == AW'(c)) begin
        case (addr[1:0])
          REG_CTRL:   rd_data_d = 32'(ctrl_w[c]);
          REG_PERIOD: rd_data_d = 32'(period_w[c]);
          REG_TARGET: rd_data_d = 32'(target_w[c]);
          default: begin
            rd_data_d = 32'(status_w[c]);
            // Wide position counters expose their upper bits in the STATUS word.
            if (POS_W > 24) rd_data_d[31:8] = pos32[c][31:8];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign irq     = |done_v;

endmodule

// File: tb/tb_stepper_io_ctrl.sv
// Directed bench for stepper_io_ctrl (N_CH=2, full-step build) with hand-computed expectations.
module tb_stepper_io_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  coils;
  logic [1:0]  limit;
  logic [1:0]  busy;
  logic        irq;
  logic [31:0] rv;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  stepper_io_ctrl #(.N_CH(2), .PERIOD_W(24), .STEP_W(16), .POS_W(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .coils   (coils),
    .limit   (limit),
    .busy    (busy),
    .irq     (irq)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    wr_en   = 1'b1;
    addr    = 3'(ch * 4 + r);
    wr_data = d;
    @(posedge clock);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic rd(input int ch, input int r, output logic [31:0] d);
    addr = 3'(ch * 4 + r);
    @(posedge clock);
    #1;
    d = rd_data;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; addr = '0; wr_data = '0; limit = '0;
    tick(2);
    reset = 1'b0;
    chk("rst_coils", 32'(coils), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_rd", rd_data, 32'h0);
    rd(0, 3, rv); chk("rst_status0", rv, 32'h0);

    // ch0 forward, PERIOD=4, TARGET=3
    wr(0, 1, 4); wr(0, 2, 3);
    rd(0, 1, rv); chk("period0_rb", rv, 32'd4);
    wr(0, 0, 32'h03);
    chk("run0_busy", 32'(busy), 32'h1);
    chk("run0_coils_t0", 32'(coils), 32'h0C);
    tick(3); chk("run0_coils_t3", 32'(coils), 32'h0C);
    tick(1); chk("run0_step1", 32'(coils), 32'h06);
    tick(4); chk("run0_step2", 32'(coils), 32'h03);
    tick(3); chk("run0_t11", 32'(coils), 32'h03);
    tick(1); chk("run0_step3", 32'(coils), 32'h09);
    chk("run0_irq_t12", 32'(irq), 32'h0);
    tick(1);
    chk("run0_irq_t13", 32'(irq), 32'h1);
    chk("run0_busy_t13", 32'(busy), 32'h0);
    chk("run0_coils_idle", 32'(coils), 32'h0);
    chk("run0_pos", dut.g_ch[0].u_ch.pos_q, 32'd3);
    rd(0, 3, rv); chk("run0_status", rv, 32'h32);

    // ch0 one more forward step with hold: phase 3 wraps to 0
    wr(0, 2, 1); wr(0, 0, 32'h13);
    chk("wrap_irq_clr", 32'(irq), 32'h0);
    chk("wrap_coils_pre", 32'(coils), 32'h09);
    tick(4); chk("wrap_coils", 32'(coils), 32'h0C);
    tick(1);
    chk("hold_coils", 32'(coils), 32'h0C);
    chk("wrap_irq", 32'(irq), 32'h1);
    rd(0, 3, rv); chk("wrap_status", rv, 32'h02);

    // ch1 reverse, PERIOD=1 clamps to 2, TARGET=2
    wr(1, 1, 1); wr(1, 2, 2); wr(1, 0, 32'h01);
    chk("run1_coils_t0", 32'(coils), 32'hCC);
    tick(1); chk("run1_coils_t1", 32'(coils), 32'hCC);
    tick(1); chk("run1_step1", 32'(coils), 32'h9C);
    tick(2); chk("run1_step2", 32'(coils), 32'h3C);
    tick(1);
    chk("run1_done_coils", 32'(coils), 32'h0C);
    chk("run1_busy", 32'(busy), 32'h0);
    chk("run1_pos", dut.g_ch[1].u_ch.pos_q, 32'hFFFF_FFFE);
    rd(1, 3, rv); chk("run1_status", rv, 32'hFFFF_FF22);
    rd(1, 1, rv); chk("period1_rb", rv, 32'd1);

    // ch0 homing: five reverse steps, then the limit rises
    wr(0, 0, 32'h04);
    chk("home_busy", 32'(busy), 32'h1);
    chk("home_coils_t0", 32'(coils), 32'h0C);
    tick(20); chk("home_step5", 32'(coils), 32'h09);
    limit = 2'b01;
    tick(2); chk("home_busy_2clk", 32'(busy), 32'h1);
    tick(1); chk("home_exit_3clk", 32'(busy), 32'h0);
    chk("home_pos", dut.g_ch[0].u_ch.pos_q, 32'h0);
    rd(0, 3, rv); chk("home_status", rv, 32'h36);
    limit = 2'b00;

    // ch1 long run; TARGET write and start while busy are ignored for this move
    wr(1, 2, 100); wr(1, 0, 32'h03);
    wr(1, 2, 4); wr(1, 0, 32'h03);
    tick(17);
    chk("busy1_ignore", 32'(busy), 32'h2);
    wr(1, 0, 32'h08);
    chk("abort1_busy", 32'(busy), 32'h0);
    chk("abort1_pos", dut.g_ch[1].u_ch.pos_q, 32'd7);
    rd(1, 3, rv); chk("abort1_status", rv, 32'h30);
    rd(1, 2, rv); chk("target1_rb", rv, 32'd4);
    rd(1, 0, rv); chk("ctrl1_rb", rv, 32'h08);

    // ch0 reverse run hits the limit after two steps
    wr(0, 2, 10); wr(0, 0, 32'h01);
    chk("flt_irq_clr", 32'(irq), 32'h0);
    tick(8); chk("flt_step2", 32'(coils), 32'h06);
    limit = 2'b01;
    tick(2); chk("flt_busy_2clk", 32'(busy), 32'h1);
    tick(1);
    chk("flt_busy", 32'(busy), 32'h0);
    chk("flt_irq", 32'(irq), 32'h0);
    chk("flt_coils", 32'(coils), 32'h0);
    chk("flt_pos", dut.g_ch[0].u_ch.pos_q, 32'hFFFF_FFFE);
    limit = 2'b00;
    rd(0, 3, rv); chk("flt_status", rv, 32'hFFFF_FF1C);
    wr(0, 0, 32'h09);
    chk("abort_start_busy", 32'(busy), 32'h0);
    tick(2); chk("abort_start_idle", 32'(busy), 32'h0);

    // ch1 TARGET=0: done on the next clock, phase unchanged
    wr(1, 2, 0); wr(1, 0, 32'h01);
    chk("t0_busy", 32'(busy), 32'h2);
    chk("t0_irq_clr", 32'(irq), 32'h0);
    tick(1);
    chk("t0_done_busy", 32'(busy), 32'h0);
    chk("t0_irq", 32'(irq), 32'h1);
    rd(1, 3, rv); chk("t0_status", rv, 32'h32);

    // reset in the middle of a held forward run
    wr(0, 2, 10); wr(0, 0, 32'h13);
    tick(5); chk("rstrun_coils_pre", 32'(coils), 32'h03);
    #3;
    reset = 1'b1;
    #1;
    chk("rstrun_coils", 32'(coils), 32'h0);
    chk("rstrun_busy", 32'(busy), 32'h0);
    chk("rstrun_irq", 32'(irq), 32'h0);
    chk("rstrun_rd", rd_data, 32'h0);
    tick(1);
    reset = 1'b0;
    rd(0, 3, rv); chk("rstrun_status0", rv, 32'h0);
    rd(1, 3, rv); chk("rstrun_status1", rv, 32'h0);
    rd(0, 1, rv); chk("rstrun_period0", rv, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
